uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte interface between NUM_REQ requesters using round-robin arbitration.
- Captures the winning requester's byte, issues a one-cycle start strobe to the transmitter and acknowledges the requester.
- Waits for the transmitter's frame-complete pulse, then re-arbitrates.
- Sits between client logic (console, loopback, status reporter) and the UART transmit datapath, mirroring the existing UART receive path.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_W, 8, byte width per requester.
- TIMEOUT_CYC, 65535, cycles allowed in WAIT_DONE; used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester send request, level.
- req_data  in  NUM_REQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W].
- ack  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i captured.
- tx_data  out  DATA_W  byte presented to the transmitter, held stable until the next launch.
- tx_start  out  1  one-cycle launch strobe to the transmitter.
- tx_busy  in  1  transmitter is shifting a frame.
- tx_done  in  1  one-cycle pulse: frame including stop bit(s) finished.
- active_id  out  IDW  index of the current or last granted requester; IDW = max(1, clog2(NUM_REQ)).
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  one-cycle pulse on watchdog abort; tied 0 without UART_ARB_TIMEOUT_EN.

Behaviour:
Reset (async assert, sync release):
- ack, tx_start, busy, timeout_err, tx_data and active_id are all 0.
- State is IDLE.
- Round-robin pointer last_id = NUM_REQ-1, so requester 0 has first priority.
- Reset mid-frame aborts silently: no ack and no tx_start are generated afterward.

States: IDLE, WAIT_BUSY, WAIT_DONE.

IDLE:
- Launch condition: req != 0 and tx_busy == 0.
- Winner is the first i with req[i]=1, searching (last_id+1) mod NUM_REQ upward with wrap.
- At that edge, all registered:
  - tx_data <= req_data slice of the winner.
  - active_id <= winner.
  - ack[winner] <= 1.
  - tx_start <= 1.
  - Go to WAIT_BUSY.
- Latency: req sampled high -> ack and tx_start high on the next cycle, for exactly 1 cycle.
- If tx_busy = 1 in IDLE, hold with no launch.

WAIT_BUSY:
- tx_busy = 1 -> WAIT_DONE.
- tx_done = 1 (fast transmitter) -> IDLE directly, with last_id <= active_id.
- tx_done takes priority if tx_done and tx_busy are both high.

WAIT_DONE:
- tx_done = 1 -> IDLE, last_id <= active_id.
- req changes are ignored.

Requester rules:
- Hold req and req_data stable until ack.
- req still high at the next IDLE evaluation means another byte; req_data must be updated by then.
- Dropping req before ack withdraws the request with no side effect.

Other rules:
- Re-arbitration happens the cycle after returning to IDLE, so back-to-back frames have exactly 1 idle cycle between tx_done and the next tx_start.
- A single active requester is granted every frame.
- With all requesters active, grants rotate 0,1,2,...,NUM_REQ-1,0.
- ack is never asserted for more than one bit at a time.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to WAIT_BUSY and increments each cycle in WAIT_BUSY or WAIT_DONE.
  - When the count reaches TIMEOUT_CYC without tx_done: return to IDLE, last_id <= active_id, timeout_err pulses 1 cycle.
  - tx_done arriving in the same cycle as the timeout wins, with no error.
- When undefined:
  - No counter is built; timeout_err is constant 0.
  - The arbiter waits indefinitely for tx_done.

Test Plan:
- Reset/idle: rst_n=0, then release with req=0 -> all outputs 0, state IDLE; tx_busy/tx_done toggling produces no tx_start.
- Single request: req=4'b0100, req_data[23:16]=8'hA5 -> next cycle ack=4'b0100, tx_start=1, tx_data=8'hA5, active_id=2, busy=1; transmitter model raises tx_busy for 160 cycles then pulses tx_done -> busy=0 one cycle later.
- Round robin: req=4'b1111 held with distinct bytes 8'h10..8'h13 -> tx_data order 10,11,12,13,10; ack order 0001,0010,0100,1000,0001; exactly 1 idle cycle between tx_done and the next tx_start.
- Wrap and priority: last_id=3, req=4'b1001 -> requester 0 granted; then with req=4'b1001 still high, requester 3 is granted next.
- Busy gating and mid-frame reset: tx_busy forced 1 in IDLE with req=4'b0001 -> no tx_start; assert rst_n=0 during WAIT_DONE -> all outputs 0 immediately, no spurious ack after release.
- Timeout (UART_ARB_TIMEOUT_EN, TIMEOUT_CYC=50): tx_start issued, no tx_done -> timeout_err pulse after 50 cycles, return to IDLE, next requester granted; separate case with tx_done on cycle 50 -> timeout_err stays 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter that shares one UART transmitter byte interface between
// NUM_REQ requesters. In IDLE it picks the next requesting client after the
// last one served, captures that client's byte, pulses tx_start and ack, and
// then waits for the transmitter's tx_done pulse before arbitrating again.
//
// Optional feature macro: UART_ARB_TIMEOUT_EN
//   When defined, a 16-bit watchdog aborts a frame that has not finished
//   within TIMEOUT_CYC cycles and pulses timeout_err. When undefined, no
//   counter exists, timeout_err is constant 0, and the arbiter waits
//   indefinitely for tx_done.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   req          per-requester send request (level)
//   req_data     byte of requester i at [i*DATA_W +: DATA_W]
//   ack          one-hot, one-cycle pulse: byte of requester i captured
//   tx_data      byte presented to the transmitter, held until next launch
//   tx_start     one-cycle launch strobe to the transmitter
//   tx_busy      transmitter is shifting a frame
//   tx_done      one-cycle pulse: frame (including stop bits) finished
//   active_id    index of the current or last granted requester
//   busy         high in any state except IDLE
//   timeout_err  one-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 65535,
  localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic [IDW-1:0]            active_id,
  output logic                      busy,
  output logic                      timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t         state;
  logic [IDW-1:0] last_id;
  logic [IDW-1:0] win_id;
  logic           win_valid;
  logic           timeout_hit;

  // Round-robin search: start one past the last served requester and wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    logic [IDW-1:0] idx;
    idx       = '0;
    win_id    = '0;
    win_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(last_id) + k) % NUM_REQ);
      if (!win_valid && req[idx]) begin
        win_valid = 1'b1;
        win_id    = idx;
      end
    end
  end

  // Main FSM; all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_id   <= IDW'(NUM_REQ - 1);
      active_id <= '0;
      tx_data   <= '0;
      ack       <= '0;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register samples
      // the pre-edge values, independent of statement order.
      ack      <= '0;
      tx_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_valid && !tx_busy) begin
            tx_data   <= req_data[int'(win_id)*DATA_W +: DATA_W];
            active_id <= win_id;
            ack       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
            tx_start  <= 1'b1;
            busy      <= 1'b1;
            state     <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          // A fast transmitter may finish before we ever see tx_busy;
          // tx_done therefore wins over tx_busy.
          if (tx_done || timeout_hit) begin
            last_id <= active_id;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (tx_busy) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx_done || timeout_hit) begin
            last_id <= active_id;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] wait_cnt;
  logic        timeout_q;

  // wait_cnt is 0 in the first waiting cycle, so the abort edge is the end of
  // the TIMEOUT_CYC-th cycle spent in WAIT_BUSY/WAIT_DONE.
  assign timeout_hit = (state != IDLE) && (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      // A tx_done coinciding with the timeout completes the frame normally.
      timeout_q <= timeout_hit && !tx_done;
      if (state == IDLE) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 16'd1;
      end
    end
  end

  assign timeout_err = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
  assign timeout_err        = 1'b0;
`endif

endmodule
